// File: rtl/clock_set_controller_pkg.sv
// clock_set_controller_pkg: field select codes and mode states shared by the time-setting controller
package clock_set_controller_pkg;
  localparam logic [1:0] SELECT_SEC  = 2'd0;
  localparam logic [1:0] SELECT_MIN  = 2'd1;
  localparam logic [1:0] SELECT_HOUR = 2'd2;
  // Distinct from every field code so the Clock ignores increment while running
  localparam logic [1:0] SELECT_NONE = 2'd3;
  typedef enum logic [1:0] {ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC} state_t;
  function automatic logic [1:0] select_of(input state_t s);
    return s == ST_SET_HOUR ? SELECT_HOUR : s == ST_SET_MIN ? SELECT_MIN :
           s == ST_SET_SEC ? SELECT_SEC : SELECT_NONE;
  endfunction
  function automatic state_t next_mode(input state_t s);
    return s == ST_RUN ? ST_SET_HOUR : s == ST_SET_HOUR ? ST_SET_MIN :
           s == ST_SET_MIN ? ST_SET_SEC : ST_RUN;
  endfunction
endpackage

// File: rtl/clock_set_controller_button_debouncer.sv
// button_debouncer: 2-FF synchronizer, stability counter and one-cycle press pulse for a raw button
module button_debouncer #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk100MHz,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0] sync_ff;
  logic [CW-1:0] cnt;
  // Counter runs only while the synced input disagrees with the debounced level
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], btn_raw};
      press   <= 1'b0;
      if (sync_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC)) begin
        cnt   <= '0;
        level <= sync_ff[1];
        press <= sync_ff[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: MODE/INC buttons to Clock field select, increment pulses, auto-repeat, timeout, blink
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int HOLD_CYC       = 50_000_000,
  parameter int REPEAT_CYC     = 10_000_000,
  parameter int TIMEOUT_CYC    = 1_000_000_000,
  parameter int BLINK_HALF_CYC = 25_000_000
) (
  input  logic       clk100MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] select,
  output logic       increment,
  output logic       setting,
  output logic       blink
);
  localparam int REP_MAX = HOLD_CYC > REPEAT_CYC ? HOLD_CYC : REPEAT_CYC;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF_CYC + 1);
  state_t state, state_n;
  logic mode_level_unused, mode_press, inc_level, inc_press;
  logic armed, first, in_set, rep_hit, timeout_hit, inc_fire;
  logic [RW-1:0] rep_cnt;
  logic [TW-1:0] idle;
  logic [BW-1:0] blink_cnt;
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk100MHz(clk100MHz), .reset(reset), .btn_raw(btn_mode), .level(mode_level_unused), .press(mode_press)
  );
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
    .clk100MHz(clk100MHz), .reset(reset), .btn_raw(btn_inc), .level(inc_level), .press(inc_press)
  );
  // The clearing edge counts as the first idle cycle, so a SET state lasts exactly TIMEOUT_CYC idle cycles
  always_comb begin
    in_set      = state != ST_RUN;
    timeout_hit = in_set && idle == TW'(TIMEOUT_CYC - 1);
    rep_hit     = armed && inc_level && rep_cnt == (first ? RW'(HOLD_CYC) : RW'(REPEAT_CYC));
    inc_fire    = in_set && !mode_press && !timeout_hit && (inc_press || rep_hit);
    state_n     = mode_press ? next_mode(state) : timeout_hit ? ST_RUN : state;
  end
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) state <= ST_RUN;
    else state <= state_n;
  end
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      select    <= SELECT_NONE;
      increment <= 1'b0;
      setting   <= 1'b0;
      blink     <= 1'b0;
      armed     <= 1'b0;
      first     <= 1'b0;
      rep_cnt   <= '0;
      idle      <= '0;
      blink_cnt <= '0;
    end else begin
      select    <= select_of(state_n);
      setting   <= state_n != ST_RUN;
      increment <= inc_fire;
      armed     <= inc_fire && inc_press ? 1'b1 : armed && inc_level && !mode_press && state_n != ST_RUN;
      first     <= inc_fire ? inc_press : first;
      rep_cnt   <= inc_fire ? RW'(1) : rep_cnt == RW'(REP_MAX) ? rep_cnt : rep_cnt + RW'(1);
      idle      <= (state_n == ST_RUN || mode_press || inc_press || inc_fire) ? '0 :
                   idle == TW'(TIMEOUT_CYC) ? idle : idle + TW'(1);
      if (state_n == ST_RUN) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (state_n != state || inc_fire) begin
        blink     <= 1'b1;
        blink_cnt <= BW'(1);
      end else if (blink_cnt == BW'(BLINK_HALF_CYC)) begin
        blink     <= ~blink;
        blink_cnt <= BW'(1);
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed scenarios for the time-setting controller with small timing parameters
module tb_clock_set_controller;
  import clock_set_controller_pkg::*;
  logic clk100MHz = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [1:0] select;
  logic increment, setting, blink;
  int compared = 0, mismatched = 0, cyc = 0;
  int pulses[$];
  logic [1:0] prev_sel = SELECT_NONE;

  clock_set_controller #(
    .DEBOUNCE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(5), .TIMEOUT_CYC(100), .BLINK_HALF_CYC(8)
  ) dut (
    .clk100MHz(clk100MHz), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .select(select), .increment(increment), .setting(setting), .blink(blink)
  );

  always #5 clk100MHz = ~clk100MHz;
  always @(posedge clk100MHz) cyc <= cyc + 1;

  // Records every increment pulse and checks it never coincides with a select change or SELECT_NONE
  always @(negedge clk100MHz) begin
    if (increment) begin
      pulses.push_back(cyc);
      compared++;
      if (select === SELECT_NONE || select !== prev_sel) begin
        mismatched++;
        $display("FAIL inc_invariant: at cycle %0d select=%0d prev=%0d", cyc, select, prev_sel);
      end
    end
    prev_sel = select;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100MHz);
  endtask

  task automatic mode_press();
    btn_mode = 1'b1; tick(10); btn_mode = 1'b0; tick(10);
  endtask

  task automatic test_reset();
    tick(2);
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL reset_select: got %0d expected %0d", select, SELECT_NONE); end
    compared++; if (increment !== 1'b0) begin mismatched++; $display("FAIL reset_increment: got %b expected 0", increment); end
    compared++; if (setting !== 1'b0) begin mismatched++; $display("FAIL reset_setting: got %b expected 0", setting); end
    compared++; if (blink !== 1'b0) begin mismatched++; $display("FAIL reset_blink: got %b expected 0", blink); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_mode_fsm();
    btn_mode = 1'b1; tick(3); btn_mode = 1'b0; tick(12);
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL short_glitch: select %0d expected %0d", select, SELECT_NONE); end
    btn_mode = 1'b1; tick(7);
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL latency_early: select %0d expected %0d", select, SELECT_NONE); end
    tick(1);
    compared++; if (select !== SELECT_HOUR) begin mismatched++; $display("FAIL latency_hour: select %0d expected %0d", select, SELECT_HOUR); end
    compared++; if (setting !== 1'b1) begin mismatched++; $display("FAIL hour_setting: got %b expected 1", setting); end
    compared++; if (blink !== 1'b1) begin mismatched++; $display("FAIL blink_entry: got %b expected 1", blink); end
    btn_mode = 1'b0; tick(7);
    compared++; if (blink !== 1'b1) begin mismatched++; $display("FAIL blink_hold: got %b expected 1", blink); end
    tick(1);
    compared++; if (blink !== 1'b0) begin mismatched++; $display("FAIL blink_toggle: got %b expected 0", blink); end
    tick(10);
    mode_press();
    compared++; if (select !== SELECT_MIN) begin mismatched++; $display("FAIL fsm_min: select %0d expected %0d", select, SELECT_MIN); end
    mode_press();
    compared++; if (select !== SELECT_SEC) begin mismatched++; $display("FAIL fsm_sec: select %0d expected %0d", select, SELECT_SEC); end
    mode_press();
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL fsm_run: select %0d expected %0d", select, SELECT_NONE); end
    compared++; if (setting !== 1'b0 || blink !== 1'b0) begin mismatched++; $display("FAIL fsm_run_flags: setting %b blink %b expected 0 0", setting, blink); end
  endtask

  task automatic test_inc_tap();
    int s;
    mode_press(); mode_press();
    compared++; if (select !== SELECT_MIN) begin mismatched++; $display("FAIL tap_enter_min: select %0d expected %0d", select, SELECT_MIN); end
    pulses.delete();
    s = cyc;
    btn_inc = 1'b1; tick(6); btn_inc = 1'b0; tick(2);
    compared++; if (increment !== 1'b1 || blink !== 1'b1) begin mismatched++; $display("FAIL tap_pulse: increment %b blink %b expected 1 1", increment, blink); end
    tick(7);
    compared++; if (blink !== 1'b1) begin mismatched++; $display("FAIL tap_blink_phase: got %b expected 1", blink); end
    tick(1);
    compared++; if (blink !== 1'b0) begin mismatched++; $display("FAIL tap_blink_toggle: got %b expected 0", blink); end
    tick(6);
    compared++; if (pulses.size() !== 1) begin mismatched++; $display("FAIL tap_count: got %0d pulses expected 1", pulses.size()); end
    compared++; if ((pulses.size() > 0 ? pulses[0] : -1) !== s + 8) begin mismatched++; $display("FAIL tap_time: got cycle %0d expected %0d", pulses.size() > 0 ? pulses[0] : -1, s + 8); end
    mode_press(); mode_press();
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL tap_back_run: select %0d expected %0d", select, SELECT_NONE); end
    pulses.delete();
    btn_inc = 1'b1; tick(6); btn_inc = 1'b0; tick(12);
    compared++; if (pulses.size() !== 0) begin mismatched++; $display("FAIL tap_in_run: got %0d pulses expected 0", pulses.size()); end
  endtask

  task automatic test_auto_repeat();
    int s, got;
    int exp_k[9] = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
    mode_press();
    pulses.delete();
    s = cyc;
    btn_inc = 1'b1; tick(60); btn_inc = 1'b0; tick(30);
    compared++; if (pulses.size() !== 9) begin mismatched++; $display("FAIL repeat_count: got %0d pulses expected 9", pulses.size()); end
    for (int i = 0; i < 9; i++) begin
      got = i < pulses.size() ? pulses[i] : -1;
      compared++; if (got !== s + 1 + exp_k[i]) begin mismatched++; $display("FAIL repeat_time[%0d]: got cycle %0d expected %0d", i, got, s + 1 + exp_k[i]); end
    end
    mode_press(); mode_press(); mode_press();
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL repeat_exit: select %0d expected %0d", select, SELECT_NONE); end
  endtask

  task automatic test_simultaneous();
    mode_press(); mode_press();
    pulses.delete();
    btn_mode = 1'b1; btn_inc = 1'b1; tick(10);
    btn_mode = 1'b0; tick(40);
    btn_inc = 1'b0; tick(12);
    compared++; if (select !== SELECT_SEC) begin mismatched++; $display("FAIL simul_select: select %0d expected %0d", select, SELECT_SEC); end
    compared++; if (pulses.size() !== 0) begin mismatched++; $display("FAIL simul_pulses: got %0d pulses expected 0", pulses.size()); end
    mode_press();
  endtask

  task automatic test_timeout();
    int ec;
    btn_mode = 1'b1; tick(8); btn_mode = 1'b0;
    compared++; if (select !== SELECT_HOUR) begin mismatched++; $display("FAIL to_enter: select %0d expected %0d", select, SELECT_HOUR); end
    tick(99);
    compared++; if (select !== SELECT_HOUR) begin mismatched++; $display("FAIL to_before: select %0d expected %0d", select, SELECT_HOUR); end
    tick(1);
    compared++; if (select !== SELECT_NONE || setting !== 1'b0) begin mismatched++; $display("FAIL to_expire: select %0d setting %b expected %0d 0", select, setting, SELECT_NONE); end
    btn_mode = 1'b1; tick(8); btn_mode = 1'b0;
    ec = cyc;
    pulses.delete();
    tick(83);
    btn_inc = 1'b1; tick(6); btn_inc = 1'b0;
    tick(101);
    compared++; if (select !== SELECT_HOUR) begin mismatched++; $display("FAIL to_extended: select %0d expected %0d", select, SELECT_HOUR); end
    compared++; if (pulses.size() !== 1 || (pulses.size() > 0 ? pulses[0] : -1) !== ec + 91) begin mismatched++; $display("FAIL to_tap_pulse: count %0d first %0d expected 1 at %0d", pulses.size(), pulses.size() > 0 ? pulses[0] : -1, ec + 91); end
    tick(1);
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL to_expire2: select %0d expected %0d", select, SELECT_NONE); end
  endtask

  task automatic test_reset_mid();
    mode_press();
    btn_inc = 1'b1; tick(28);
    compared++; if (increment !== 1'b1) begin mismatched++; $display("FAIL mid_repeat_pulse: got %b expected 1", increment); end
    reset = 1'b1; btn_mode = 1'b1;
    #1;
    compared++; if (increment !== 1'b0 || blink !== 1'b0) begin mismatched++; $display("FAIL mid_async_flags: increment %b blink %b expected 0 0", increment, blink); end
    compared++; if (select !== SELECT_NONE || setting !== 1'b0) begin mismatched++; $display("FAIL mid_async_select: select %0d setting %b expected %0d 0", select, setting, SELECT_NONE); end
    tick(3);
    btn_inc = 1'b0; reset = 1'b0;
    tick(7);
    compared++; if (select !== SELECT_NONE) begin mismatched++; $display("FAIL mid_release_early: select %0d expected %0d", select, SELECT_NONE); end
    tick(1);
    compared++; if (select !== SELECT_HOUR) begin mismatched++; $display("FAIL mid_release_hour: select %0d expected %0d", select, SELECT_HOUR); end
    btn_mode = 1'b0; tick(10);
  endtask

  initial begin
    test_reset();
    test_mode_fsm();
    test_inc_tap();
    test_auto_repeat();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
